pixel_streamer: RTL
===================

// Module: pixel_streamer
// PURPOSE
//  Raster-order feature-map reader: fetches a stage_width x stage_height 8-bit map
//  from single-port sync RAM (1-cycle read latency) and emits one pixel per cycle
//  into the 3x3 window collector.
//  Flags the pixels that complete an in-bounds 3x3 window (win_valid).
//  Sits between feature-map memory and the collector / conv PE array.
//  Start/busy/done handshake per stage; valid/ready on the pixel output.
// PARAMETERS
//  ADDR_W   16  RAM address width; addresses wrap modulo 2**ADDR_W
//  DIM_W    8   width of stage_width / stage_height / row / col
// PORTS
//  clk          in   1       rising-edge clock (only clock)
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse; accepted only in IDLE
//  base_addr    in   ADDR_W  address of pixel (0,0); sampled on accepted start
//  stage_width  in   DIM_W   pixels per row; sampled on accepted start
//  stage_height in   DIM_W   rows per frame; sampled on accepted start
//  mem_rd_en    out  1       RAM read strobe
//  mem_addr     out  ADDR_W  RAM read address
//  mem_rdata    in   8       RAM data, valid the cycle after mem_rd_en
//  pixel_out    out  8       current pixel
//  pixel_valid  out  1       pixel_out/row/col/win_valid/eol/eof are meaningful
//  pixel_ready  in   1       downstream accepts pixel (transfer = valid & ready)
//  row, col     out  DIM_W   coordinates of pixel_out
//  win_valid    out  1       row>=2 && col>=2 for the presented pixel
//  eol, eof     out  1       last pixel of row / last pixel of frame
//  busy         out  1       high from accepted start until the done cycle
//  done         out  1       1-cycle pulse after the last transfer
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; skid buffer empty; no read in flight.
//  FSM: IDLE -start-> RUN (if width!=0 && height!=0) else -> DONE.
//   RUN: issue reads in raster order; -> DRAIN when last address issued.
//   DRAIN: wait until skid buffer empty and no read in flight -> DONE.
//   DONE: done=1 for one cycle, busy=0 -> IDLE. start in RUN/DRAIN/DONE ignored.
//  busy=1 in RUN and DRAIN; 0 in IDLE and DONE.
//  Read issue: mem_rd_en=1 in RUN when (buffered + in_flight) < 2, counting a
//   transfer in the same cycle as freeing a slot. 2-entry skid FIFO gives
//   1 pixel/cycle while pixel_ready=1.
//  Latency: start in cycle 0 -> first mem_rd_en cycle 1 -> pixel_valid cycle 3
//   (RAM + output register).
//  mem_addr = base_addr + row_i*stage_width + col_i, computed by a running
//   increment, never a multiplier; wraps modulo 2**ADDR_W.
//  row/col/win_valid/eol/eof are carried with each pixel through the FIFO.
//  Output holds stable while pixel_valid && !pixel_ready; no data is lost or
//   duplicated under any stall pattern.
//  Widths: col steps 0..stage_width-1, then 0 with row+1.
//   eol when col==stage_width-1; eof when eol && row==stage_height-1.
//   width==1: every pixel has eol=1.
//  Exactly width*height transfers per frame; pixel_valid=0 in DONE and IDLE.
//  Collector has no enable, so pixel_ready must be held 1 when feeding it
//   directly; stall support is for gated consumers.
//  Async reset mid-frame: abort immediately to reset state; the late RAM
//   response is discarded; no done pulse.
// TESTING
//  4x3 frame, base=0x0010, RAM[a]=a[7:0], ready=1 -> 12 transfers 0x10..0x1B on
//   consecutive cycles from cycle 3; eol at col 3; eof on 0x1B; done 1 cycle later.
//  Same frame, ready toggled 1,0,0,1 -> same 12-pixel sequence, outputs stable
//   while stalled; no more than 2 reads outstanding.
//  5x5 frame -> win_valid=1 exactly at (2..4,2..4), 9 pixels.
//  stage_width=0 -> no mem_rd_en, no pixel_valid, done pulse cycle 1.
//  start pulsed during RUN -> ignored, frame unaffected.
//  base=0xFFFE, 2x2 -> addresses FFFE, FFFF, 0000, 0001.
//  rst_n low after 5 transfers -> outputs 0 at once; new start replays from (0,0).

Source files
------------

// File: rtl/pixel_streamer.sv
// Raster-order feature-map reader with a 2-entry skid FIFO and per-pixel window tags.
// Latency: start -> first read +1 cycle -> first pixel_valid +3 cycles; backpressure via pixel_ready, reads throttled to 2 outstanding.

// Small synchronous FIFO: show-ahead read port, occupancy count exposed.
// Latency: write visible on rd_dat the cycle after wr_vld; backpressure: writes dropped when full without a pop.
module sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  assign pop    = rd_rdy && (cnt_q != '0);
  assign push   = wr_vld && ((cnt_q != CW'(DEPTH)) || pop);
  assign rd_vld = (cnt_q != '0);
  assign rd_dat = mem_q[rptr_q];
  assign cnt    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wr_dat;
        wptr_q        <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module pixel_streamer #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  stage_width,
  input  logic [DIM_W-1:0]  stage_height,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              win_valid,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);
  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             win;
    logic             eol;
    logic             eof;
  } meta_t;

  typedef struct packed {
    logic [7:0] pix;
    meta_t      meta;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIM_W-1:0]  rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]  col_last, row_last;
  logic              inflight_q;
  meta_t             inflight_meta_q, issue_meta;
  logic              issue, xfer, rd_last;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  pix_t              wr_pix, head;

  assign col_last = width_q - {{(DIM_W-1){1'b0}}, 1'b1};
  assign row_last = height_q - {{(DIM_W-1){1'b0}}, 1'b1};
  assign rd_last  = (rd_col_q == col_last) && (rd_row_q == row_last);
  assign xfer     = pixel_valid && pixel_ready;
  // A transfer this cycle frees its slot in time for a new read to land in it.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, xfer};

  always_comb begin
    issue_meta.row = rd_row_q;
    issue_meta.col = rd_col_q;
    issue_meta.win = (rd_row_q >= DIM_W'(2)) && (rd_col_q >= DIM_W'(2));
    issue_meta.eol = (rd_col_q == col_last);
    issue_meta.eof = (rd_col_q == col_last) && (rd_row_q == row_last);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    width_d  = width_q;
    height_d = height_q;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = stage_width;
          height_d = stage_height;
          addr_d   = base_addr;
          rd_row_d = '0;
          rd_col_d = '0;
          state_d  = ((stage_width != '0) && (stage_height != '0)) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (occ < 3'd2) begin
          issue  = 1'b1;
          // Raster order is contiguous, so the address just counts up.
          addr_d = addr_q + 1'b1;
          if (rd_col_q == col_last) begin
            rd_col_d = '0;
            rd_row_d = rd_row_q + 1'b1;
          end else begin
            rd_col_d = rd_col_q + 1'b1;
          end
          if (rd_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && xfer))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      width_q  <= width_d;
      height_q <= height_d;
    end
  end

  // Tags travel alongside the read so they line up with mem_rdata next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_meta_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_meta_q <= issue_meta;
    end
  end

  always_comb begin
    wr_pix.pix  = mem_rdata;
    wr_pix.meta = inflight_meta_q;
  end

  sfifo #(
    .W     ($bits(pix_t)),
    .DEPTH (2)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (inflight_q),
    .wr_dat (wr_pix),
    .rd_vld (pixel_valid),
    .rd_rdy (pixel_ready),
    .rd_dat (head),
    .cnt    (fifo_cnt)
  );

  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign pixel_out = head.pix;
  assign row       = head.meta.row;
  assign col       = head.meta.col;
  assign win_valid = head.meta.win;
  assign eol       = head.meta.eol;
  assign eof       = head.meta.eof;
endmodule
